// File: rtl/layer2_discriminator.sv
// Second discriminator dense layer: NUM_IN Q8.8 inputs -> NUM_OUT Q8.8 outputs with LeakyReLU,
// computed by one shared MAC that walks every neuron in turn.
module layer2_discriminator #(
  parameter int NUM_IN     = 256,
  parameter int NUM_OUT    = 32,
  parameter int LEAK_SHIFT = 2,
  parameter int W_AW       = 13,
  parameter int B_AW       = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_IN*16-1:0]    flat_input_flat,
  input  logic                    w_wr_en,
  input  logic [W_AW-1:0]         w_wr_addr,
  input  logic [15:0]             w_wr_data,
  input  logic                    b_wr_en,
  input  logic [B_AW-1:0]         b_wr_addr,
  input  logic [15:0]             b_wr_data,
  output logic [NUM_OUT*16-1:0]   flat_output_flat,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, MAC, FINISH, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] w_mem [NUM_IN*NUM_OUT];
  logic signed [15:0] b_mem [NUM_OUT];
  logic signed [15:0] x_p0  [NUM_IN];
  logic signed [15:0] y_p1  [NUM_OUT];
  logic [IW-1:0]      i_q;
  logic [OW-1:0]      o_q;
  logic signed [47:0] acc_p1;
  logic [W_AW-1:0]    w_idx;
  logic signed [31:0] prod_p0;
  logic signed [47:0] bias_ext;
  logic signed [47:0] sum_p1;
  logic signed [15:0] y_new;

  function automatic logic signed [15:0] sat16(input logic signed [47:0] v);
    if (v > 48'sd32767)       return 16'sh7FFF;
    else if (v < -48'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [15:0] leaky(input logic signed [15:0] s);
    return (s < 0) ? (s >>> LEAK_SHIFT) : s;
  endfunction

  // MAC stage: latched input times weight, widened to the accumulator
  assign w_idx   = W_AW'(int'(o_q) * NUM_IN + int'(i_q));
  assign prod_p0 = x_p0[i_q] * w_mem[w_idx];

  // FINISH stage: bias aligned to Q16.16, back to Q8.8 by floor shift, saturate, leak
  assign bias_ext = {{24{b_mem[o_q][15]}}, b_mem[o_q], 8'h00};
  assign sum_p1   = acc_p1 + bias_ext;
  assign y_new    = leaky(sat16(sum_p1 >>> 8));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LATCH;
      LATCH:   state_d = MAC;
      MAC:     if (i_q == IW'(NUM_IN - 1)) state_d = FINISH;
      FINISH:  state_d = (o_q == OW'(NUM_OUT - 1)) ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      o_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == LATCH) || (state_d == MAC) || (state_d == FINISH);
      done    <= (state_q == DONE);
      case (state_q)
        LATCH: begin
          i_q <= '0;
          o_q <= '0;
        end
        MAC: i_q <= i_q + 1'b1;
        FINISH: begin
          i_q <= '0;
          if (o_q != OW'(NUM_OUT - 1)) o_q <= o_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      LATCH:   acc_p1 <= '0;
      MAC:     acc_p1 <= acc_p1 + {{16{prod_p0[31]}}, prod_p0};
      FINISH:  acc_p1 <= '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == LATCH)
      for (int i = 0; i < NUM_IN; i++) x_p0[i] <= flat_input_flat[i*16 +: 16];
  end

  // Results persist across runs; a slot only changes in its own FINISH
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_OUT; o++) y_p1[o] <= '0;
    end else if (state_q == FINISH) begin
      y_p1[o_q] <= y_new;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (w_wr_en && (32'(w_wr_addr) < 32'(NUM_IN * NUM_OUT))) w_mem[w_wr_addr] <= w_wr_data;
      if (b_wr_en && (32'(b_wr_addr) < 32'(NUM_OUT)))          b_mem[b_wr_addr] <= b_wr_data;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign flat_output_flat[g*16 +: 16] = y_p1[g];
  end

endmodule

// File: tb/tb_layer2_discriminator.sv
// Bench for layer2_discriminator: directed runs with a scoreboard queue checked by a monitor thread.
module tb_layer2_discriminator;

  localparam int NUM_IN   = 256;
  localparam int NUM_OUT  = 32;
  localparam int W_AW     = 13;
  localparam int B_AW     = 5;
  localparam int IN_W     = NUM_IN * 16;
  localparam int OUT_W    = NUM_OUT * 16;
  localparam int LAT      = 2 + NUM_OUT * (NUM_IN + 1);
  localparam int BUSY_LEN = 1 + NUM_OUT * (NUM_IN + 1);

  logic             clk;
  logic             rst;
  logic             start;
  logic [IN_W-1:0]  flat_input_flat;
  logic             w_wr_en;
  logic [W_AW-1:0]  w_wr_addr;
  logic [15:0]      w_wr_data;
  logic             b_wr_en;
  logic [B_AW-1:0]  b_wr_addr;
  logic [15:0]      b_wr_data;
  logic [OUT_W-1:0] flat_output_flat;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [OUT_W-1:0] exp_bus_q[$];
  int               exp_cyc_q[$];

  layer2_discriminator #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .LEAK_SHIFT(2), .W_AW(W_AW), .B_AW(B_AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .flat_input_flat(flat_input_flat),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .flat_output_flat(flat_output_flat), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] fill_in(input logic [15:0] v);
    return {NUM_IN{v}};
  endfunction

  function automatic logic [OUT_W-1:0] fill_out(input logic [15:0] v);
    return {NUM_OUT{v}};
  endfunction

  task automatic monitor();
    logic             done_prev = 1'b0;
    logic             busy_prev = 1'b0;
    int               busy_len  = 0;
    logic [OUT_W-1:0] eb;
    int               ec;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_prev = 1'b0;
        busy_prev = 1'b0;
        busy_len  = 0;
      end else begin
        if (busy) busy_len = busy_prev ? busy_len + 1 : 1;
        if (done) begin
          chk("done_width", OUT_W'(done_prev), '0);
          if (exp_bus_q.size() == 0) begin
            chk("unexpected_done", OUT_W'(1), '0);
          end else begin
            eb = exp_bus_q.pop_front();
            ec = exp_cyc_q.pop_front();
            chk("done_cycle", OUT_W'(cyc), OUT_W'(ec));
            chk("busy_len", OUT_W'(busy_len), OUT_W'(BUSY_LEN));
            for (int o = 0; o < NUM_OUT; o++)
              chk($sformatf("out[%0d]", o), OUT_W'(flat_output_flat[o*16 +: 16]), OUT_W'(eb[o*16 +: 16]));
          end
        end
        done_prev = done;
        busy_prev = busy;
      end
    end
  endtask

  task automatic write_diag(input logic [15:0] wv, input logic wr_bias, input logic [15:0] bv);
    for (int o = 0; o < NUM_OUT; o++) begin
      w_wr_en   = 1'b1;
      w_wr_addr = W_AW'(o * NUM_IN + o);
      w_wr_data = wv;
      b_wr_en   = wr_bias;
      b_wr_addr = B_AW'(o);
      b_wr_data = bv;
      @(posedge clk); #1;
    end
    w_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  task automatic write_bias_all(input logic [15:0] bv);
    for (int o = 0; o < NUM_OUT; o++) begin
      b_wr_en   = 1'b1;
      b_wr_addr = B_AW'(o);
      b_wr_data = bv;
      @(posedge clk); #1;
    end
    b_wr_en = 1'b0;
  endtask

  // disturb_at > 0 injects start, a weight write, a bias write and new inputs that many cycles in
  task automatic run_layer(input logic [OUT_W-1:0] exp_bus, input logic [IN_W-1:0] xin, input int disturb_at);
    flat_input_flat = xin;
    start = 1'b1;
    exp_bus_q.push_back(exp_bus);
    exp_cyc_q.push_back(cyc + 1 + LAT);
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t < LAT + 50 && exp_bus_q.size() != 0; t++) begin
      if (t == disturb_at) begin
        start           = 1'b1;
        flat_input_flat = fill_in(16'hFF9C);
        w_wr_en         = 1'b1;
        w_wr_addr       = W_AW'(5 * NUM_IN + 5);
        w_wr_data       = 16'h0000;
        b_wr_en         = 1'b1;
        b_wr_addr       = B_AW'(5);
        b_wr_data       = 16'h0100;
      end else begin
        start   = 1'b0;
        w_wr_en = 1'b0;
        b_wr_en = 1'b0;
      end
      @(posedge clk); #1;
    end
    start   = 1'b0;
    w_wr_en = 1'b0;
    b_wr_en = 1'b0;
    if (exp_bus_q.size() != 0) begin
      chk("done_timeout", OUT_W'(1), '0);
      exp_bus_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  initial begin
    logic [OUT_W-1:0] eb;
    rst = 1'b1; start = 1'b0; flat_input_flat = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", OUT_W'(busy), '0);
    chk("rst_done", OUT_W'(done), '0);
    chk("rst_out", flat_output_flat, '0);
    rst = 1'b0;

    // zero weights everywhere, bias[o] = o in Q8.8
    for (int a = 0; a < NUM_IN * NUM_OUT; a++) begin
      w_wr_en   = 1'b1;
      w_wr_addr = W_AW'(a);
      w_wr_data = 16'h0000;
      b_wr_en   = (a < NUM_OUT);
      b_wr_addr = B_AW'(a);
      b_wr_data = 16'(a * 256);
      @(posedge clk); #1;
    end
    w_wr_en = 1'b0;
    b_wr_en = 1'b0;
    for (int o = 0; o < NUM_OUT; o++) eb[o*16 +: 16] = 16'(o * 256);
    run_layer(eb, fill_in(16'h1234), 0);
    chk("out3_bias", OUT_W'(flat_output_flat[3*16 +: 16]), OUT_W'(16'h0300));

    // bias -4.0 -> leaky -1.0
    write_bias_all(16'hFC00);
    run_layer(fill_out(16'hFF00), fill_in(16'h0000), 0);

    // identity on the diagonal, bias 0; disturbed run must match the clean result
    write_diag(16'h0100, 1'b1, 16'h0000);
    run_layer(fill_out(16'h0064), fill_in(16'h0064), 100);
    chk("w5_kept_after_disturb", OUT_W'(flat_output_flat[5*16 +: 16]), OUT_W'(16'h0064));
    run_layer(fill_out(16'hFFE7), fill_in(16'hFF9C), 0);

    // reset part-way through a run
    flat_input_flat = fill_in(16'h0064);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2999) @(posedge clk);
    #1;
    chk("midrun_busy", OUT_W'(busy), OUT_W'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", OUT_W'(busy), '0);
    chk("abort_done", OUT_W'(done), '0);
    chk("abort_out", flat_output_flat, '0);
    rst = 1'b0;
    run_layer(fill_out(16'h0064), fill_in(16'h0064), 0);

    // saturation: positive clips at max, negative clips at min then leaks
    write_diag(16'h7FFF, 1'b0, 16'h0000);
    run_layer(fill_out(16'h7FFF), fill_in(16'h7FFF), 0);
    write_diag(16'h8000, 1'b0, 16'h0000);
    run_layer(fill_out(16'hE000), fill_in(16'h7FFF), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("idle_done_low", OUT_W'(done), '0);
    chk("idle_out_stable", flat_output_flat, fill_out(16'hE000));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
